// File: rtl/sel_sequencer.sv
// Display-selector front end: latches one ALU transaction and walks a one-hot
// select across A, B, opcode and Y, DWELL cycles each. Optional hold: SEQ_HOLD_EN.
module sel_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic [2:0] op_in,
  input  logic [7:0] Y_in,
`ifdef SEQ_HOLD_EN
  input  logic       hold,
`endif
  output logic [3:0] select,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] opCodeA,
  output logic [7:0] Y,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SHOW_A  = 3'd1;
  localparam logic [2:0] SHOW_B  = 3'd2;
  localparam logic [2:0] SHOW_OP = 3'd3;
  localparam logic [2:0] SHOW_Y  = 3'd4;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [7:0] y;
  } txn_t;

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  txn_t       txn_q, txn_d;
  logic       done_q, done_d;
  logic       hold_w;

`ifdef SEQ_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    txn_d   = txn_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (load) begin
          state_d = SHOW_A;
          txn_d   = '{a: A_in, b: B_in, op: op_in, y: Y_in};
        end
      end
      SHOW_A, SHOW_B, SHOW_OP, SHOW_Y: begin
        // a held cycle freezes both state and dwell count
        if (!hold_w) begin
          if (cnt_q == LAST) begin
            cnt_d = 8'd0;
            case (state_q)
              SHOW_A:  state_d = SHOW_B;
              SHOW_B:  state_d = SHOW_OP;
              SHOW_OP: state_d = SHOW_Y;
              default: begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            endcase
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      txn_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txn_q   <= txn_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    select = 4'b0000;
    case (state_q)
      SHOW_A:  select = 4'b0001;
      SHOW_B:  select = 4'b0010;
      SHOW_OP: select = 4'b1000;
      SHOW_Y:  select = 4'b0100;
      default: select = 4'b0000;
    endcase
  end

  assign A       = txn_q.a;
  assign B       = txn_q.b;
  assign opCodeA = txn_q.op;
  assign Y       = txn_q.y;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule
